// File: rtl/wb_merge_unit.sv
// Writeback merger: per-source select + FIFO, one register-file write per cycle,
// registered write port and a pending-destination mask for hazard detection.
module wb_merge_unit #(
  parameter int NUM_SRC    = 3,
  parameter int XLEN       = 32,
  parameter int RA_W       = 5,
  parameter int FIFO_DEPTH = 2,
  parameter int PRIO_MODE  = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC-1:0]        src_regwrite,
  input  logic [NUM_SRC*RA_W-1:0]   src_rd_addr,
  input  logic [NUM_SRC*2-1:0]      src_sel,
  input  logic [NUM_SRC*XLEN-1:0]   src_alu,
  input  logic [NUM_SRC*XLEN-1:0]   src_mem,
  input  logic [NUM_SRC*XLEN-1:0]   src_pc,
  input  logic [NUM_SRC*XLEN-1:0]   src_imm,
  output logic                      rf_we,
  output logic [RA_W-1:0]           rf_waddr,
  output logic [XLEN-1:0]           rf_wdata,
  output logic [(1<<RA_W)-1:0]      pending_mask
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [RA_W-1:0]  r_mem_addr [NUM_SRC][FIFO_DEPTH];
  logic [XLEN-1:0]  r_mem_data [NUM_SRC][FIFO_DEPTH];
  logic [PTR_W-1:0] r_rd_ptr   [NUM_SRC];
  logic [PTR_W-1:0] r_wr_ptr   [NUM_SRC];
  logic [CNT_W-1:0] r_count    [NUM_SRC];
  logic [SRC_W-1:0] r_rr_ptr;

  logic [NUM_SRC-1:0] w_push;
  logic [NUM_SRC-1:0] w_pop;
  logic [NUM_SRC-1:0] w_nonempty;
  logic [RA_W-1:0]    w_rd    [NUM_SRC];
  logic [XLEN-1:0]    w_wdata [NUM_SRC];
  logic               w_gnt_valid;
  logic [SRC_W-1:0]   w_gnt_idx;
  logic [SRC_W:0]     w_rr_sum;
  logic [SRC_W-1:0]   w_rr_next;
  logic [RA_W-1:0]    w_head_addr;
  logic [XLEN-1:0]    w_head_data;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [1:0] w_sel;
      assign w_sel          = src_sel[gi*2 +: 2];
      assign w_rd[gi]       = src_rd_addr[gi*RA_W +: RA_W];
      assign w_wdata[gi]    = (w_sel == 2'd0) ? src_alu[gi*XLEN +: XLEN] :
                              (w_sel == 2'd1) ? src_mem[gi*XLEN +: XLEN] :
                              (w_sel == 2'd2) ? src_pc[gi*XLEN +: XLEN]  :
                                                src_imm[gi*XLEN +: XLEN];
      // Ready depends on the registered count only, so a full FIFO never pops through.
      assign src_ready[gi]  = rst_n && (r_count[gi] < CNT_W'(FIFO_DEPTH));
      assign w_nonempty[gi] = (r_count[gi] != '0);
      assign w_push[gi]     = src_valid[gi] && src_ready[gi] && src_regwrite[gi] &&
                              (w_rd[gi] != '0);
      assign w_pop[gi]      = w_gnt_valid && (w_gnt_idx == SRC_W'(gi));
    end
  endgenerate

  always_comb begin
    logic [SRC_W:0] idx;
    idx         = '0;
    w_gnt_valid = 1'b0;
    w_gnt_idx   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (PRIO_MODE == 1) begin
        idx = (SRC_W+1)'(k);
      end else begin
        idx = {1'b0, r_rr_ptr} + (SRC_W+1)'(k);
        if (idx >= (SRC_W+1)'(NUM_SRC)) idx = idx - (SRC_W+1)'(NUM_SRC);
      end
      if (!w_gnt_valid && w_nonempty[idx[SRC_W-1:0]]) begin
        w_gnt_valid = 1'b1;
        w_gnt_idx   = idx[SRC_W-1:0];
      end
    end
  end

  assign w_rr_sum    = {1'b0, w_gnt_idx} + 1'b1;
  assign w_rr_next   = (w_rr_sum >= (SRC_W+1)'(NUM_SRC)) ? '0 : w_rr_sum[SRC_W-1:0];
  assign w_head_addr = r_mem_addr[w_gnt_idx][r_rd_ptr[w_gnt_idx]];
  assign w_head_data = r_mem_data[w_gnt_idx][r_rd_ptr[w_gnt_idx]];

  // Entry storage needs no reset: validity lives in the counts.
  always_ff @(posedge clk) begin
    for (int s = 0; s < NUM_SRC; s++) begin
      if (w_push[s]) begin
        r_mem_addr[s][r_wr_ptr[s]] <= w_rd[s];
        r_mem_data[s][r_wr_ptr[s]] <= w_wdata[s];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        r_rd_ptr[s] <= '0;
        r_wr_ptr[s] <= '0;
        r_count[s]  <= '0;
      end
      r_rr_ptr <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      for (int s = 0; s < NUM_SRC; s++) begin
        if (w_push[s]) r_wr_ptr[s] <= r_wr_ptr[s] + 1'b1;
        if (w_pop[s])  r_rd_ptr[s] <= r_rd_ptr[s] + 1'b1;
        case ({w_push[s], w_pop[s]})
          2'b10:   r_count[s] <= r_count[s] + 1'b1;
          2'b01:   r_count[s] <= r_count[s] - 1'b1;
          default: r_count[s] <= r_count[s];
        endcase
      end
      rf_we <= w_gnt_valid;
      if (w_gnt_valid) begin
        rf_waddr <= w_head_addr;
        rf_wdata <= w_head_data;
        if (PRIO_MODE == 0) r_rr_ptr <= w_rr_next;
      end
    end
  end

  always_comb begin
    logic [PTR_W-1:0] off;
    off          = '0;
    pending_mask = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int j = 0; j < FIFO_DEPTH; j++) begin
        off = PTR_W'(j) - r_rd_ptr[s];
        if ({1'b0, off} < r_count[s]) pending_mask[r_mem_addr[s][j]] = 1'b1;
      end
    end
    if (rf_we) pending_mask[rf_waddr] = 1'b1;
  end

endmodule

// File: doc/wb_merge_unit.md
Name: wb_merge_unit

Overview:
- Parametrised writeback merger: NUM_SRC result producers (main pipe, load unit, mul/div, ...) feed one register-file write port.
- Each source presents unselected writeback candidates plus a MemtoReg-style selector. The block applies the selector, buffers each source in its own FIFO, and arbitrates one write per cycle.
- Registered write-port outputs double as the WB forwarding source.
- Also exports a pending-write mask for the ID-stage hazard logic.

Parameters:
- NUM_SRC, 3, number of writeback sources (1..8)
- XLEN, 32, data width
- RA_W, 5, register address width
- FIFO_DEPTH, 2, entries per source FIFO (power of two, >=2)
- PRIO_MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- src_valid  in  NUM_SRC  per-source result valid
- src_ready  out  NUM_SRC  per-source accept
- src_regwrite  in  NUM_SRC  per-source RegWrite
- src_rd_addr  in  NUM_SRC*RA_W  destination registers, source i at [i*RA_W +: RA_W]
- src_sel  in  NUM_SRC*2  selector: 0 = ALU, 1 = MEM, 2 = PC, 3 = IMM
- src_alu, src_mem, src_pc, src_imm  in  NUM_SRC*XLEN each  candidate values
- rf_we  out  1  register-file write enable
- rf_waddr  out  RA_W  write address
- rf_wdata  out  XLEN  write data
- pending_mask  out  2**RA_W  bit r set while a write to r is buffered or on the port

Behaviour:
- Reset:
  - Asynchronous active-low clk and rst_n are fixed by design; reset is asynchronous and active-low.
  - rst_n low clears all FIFOs, counts and pointers; round-robin pointer = 0.
  - rf_we = 0, rf_waddr = 0, rf_wdata = 0, pending_mask = 0, src_ready = 0 while in reset.
  - Reset mid-operation discards all buffered results.
- Select: wdata_i = candidate chosen by src_sel[i]; evaluated combinationally at acceptance and stored in the FIFO, never re-evaluated later.
- Accept:
  - src_ready[i] = (count_i < FIFO_DEPTH), computed from the current count only. No pop-through: a full FIFO stays not-ready even in a cycle it is popped.
  - Transfer occurs when src_valid[i] && src_ready[i] at a rising edge.
  - A transfer with src_regwrite = 0 or rd_addr = 0 is consumed but not enqueued.
- FIFO: per-source, in-order, wrapping read/write pointers. Simultaneous push and pop on a non-full FIFO keeps the count unchanged.
- Arbitration (combinational each cycle over non-empty FIFOs):
  - PRIO_MODE 0: first non-empty index searching from rr_ptr upward with wrap. After a grant to g, rr_ptr <= (g+1) mod NUM_SRC. rr_ptr holds when there is no grant.
  - PRIO_MODE 1: lowest non-empty index wins; rr_ptr unused.
  - At most one pop per cycle.
- Output register: on a grant, at the next edge the head entry is popped and rf_we <= 1, rf_waddr/rf_wdata <= head. Otherwise rf_we <= 0 and waddr/wdata hold.
- Latency: input accepted at edge E into an empty, uncontended block gives rf_we = 1 in the cycle after edge E+1 (2 edges). Sustained throughput is 1 write per cycle in aggregate.
- pending_mask: OR of one-hot(rd) over all valid FIFO entries, plus rf_waddr when rf_we = 1. Purely combinational from state.
- Ordering:
  - Order within a source is preserved.
  - Across sources, ordering is not guaranteed. Issue logic must stall on pending_mask so that no two in-flight writes share an rd.

Test Plan:
- Reset: assert rst_n = 0 mid-stream with 2 entries buffered in source 1 → rf_we = 0 and pending_mask = 0 immediately; after release, src_ready = all ones and no stale write appears.
- Select/latency: src0 valid, rd = 7, sel = 2, pc = 0x104 at edge E → rf_we = 1, waddr = 7, wdata = 0x104 after edge E+1; pending_mask[7] = 1 from E until the write retires.
- Drop rules: src1 rd = 0 with regwrite = 1, then rd = 3 with regwrite = 0 → both accepted (ready stays 1); no rf_we pulse; pending_mask stays 0.
- Round-robin (PRIO_MODE = 0): all three sources each push rd = 1/2/3 in the same cycle, repeated twice → write order 1, 2, 3, 1, 2, 3; rf_we high 6 consecutive cycles.
- Fixed priority (PRIO_MODE = 1): src0 continuously valid, src2 holding one entry → src2 is written only when src0 goes idle; src0 order is preserved.
- Backpressure: hold arbitration busy, push src1 three times with FIFO_DEPTH = 2 → src_ready[1] = 0 after 2 pushes; the third is accepted only after a pop, and the data sequence is unchanged.
